// File: rtl/mask_store.sv
// mask_store
// Store-data merge unit for the memory stage. It builds the 32-bit word that is
// written back to data memory for sw/sh/sb. The low byte or halfword of the store
// source register is laid over the current memory word at the addressed lane.
// The result is registered and feeds the data-memory write-data port one cycle
// later. A new operation is accepted every cycle, with no handshake.
//
// Ports
//   Clk          in   1   system clock, rising-edge active
//   Reset        in   1   synchronous active-high reset
//   MemAdr       in   2   byte offset within the word (address bits [1:0])
//   MemData      in   32  current contents of the addressed memory word
//   RegData      in   32  store source register value
//   Bytes2Store  in   2   store size: 3=sw, 2=sh, 1=sb, 0=no store
//   out          out  32  merged word to write to memory (registered)
//   ByteEn       out  4   lanes taken from RegData, bit i = byte [8i+7:8i] (registered)
//   Misaligned   out  1   sh with odd offset or sw with nonzero offset (registered)

module mask_store (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  MemAdr,
  input  logic [31:0] MemData,
  input  logic [31:0] RegData,
  input  logic [1:0]  Bytes2Store,
  output logic [31:0] out,
  output logic [3:0]  ByteEn,
  output logic        Misaligned
);

  typedef enum logic [1:0] {
    SIZE_NONE = 2'd0,
    SIZE_BYTE = 2'd1,
    SIZE_HALF = 2'd2,
    SIZE_WORD = 2'd3
  } store_size_t;

  store_size_t size;
  logic [7:0]  store_byte;
  logic [15:0] store_half;
  logic [31:0] merged;
  logic [3:0]  lane_en;
  logic        misaligned_next;

  assign size       = store_size_t'(Bytes2Store);
  // Only the low part of RegData can ever reach the output for sub-word stores.
  assign store_byte = RegData[7:0];
  assign store_half = RegData[15:0];

  // Select the replacement lanes for each store size. Every branch assigns
  // every bit, so unselected lanes always carry MemData and never X.
  always_comb begin
    merged          = MemData;
    lane_en         = 4'h0;
    misaligned_next = 1'b0;
    case (size)
      SIZE_WORD: begin
        // The data is the whole register even when the offset is bad. The
        // flag lets the memory stage decide how to handle it.
        merged          = RegData;
        lane_en         = 4'hF;
        misaligned_next = (MemAdr != 2'b00);
      end
      SIZE_HALF: begin
        // MemAdr[0] does not select data. It only raises the misalignment flag.
        if (MemAdr[1]) begin
          merged  = {store_half, MemData[15:0]};
          lane_en = 4'hC;
        end else begin
          merged  = {MemData[31:16], store_half};
          lane_en = 4'h3;
        end
        misaligned_next = MemAdr[0];
      end
      SIZE_BYTE: begin
        case (MemAdr)
          2'd0: begin
            merged  = {MemData[31:8], store_byte};
            lane_en = 4'h1;
          end
          2'd1: begin
            merged  = {MemData[31:16], store_byte, MemData[7:0]};
            lane_en = 4'h2;
          end
          2'd2: begin
            merged  = {MemData[31:24], store_byte, MemData[15:0]};
            lane_en = 4'h4;
          end
          default: begin
            merged  = {store_byte, MemData[23:0]};
            lane_en = 4'h8;
          end
        endcase
      end
      default: begin
        merged          = MemData;
        lane_en         = 4'h0;
        misaligned_next = 1'b0;
      end
    endcase
  end

  // Output register. Reset wins over any operation presented on the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out        <= 32'h0;
      ByteEn     <= 4'h0;
      Misaligned <= 1'b0;
    end else begin
      out        <= merged;
      ByteEn     <= lane_en;
      Misaligned <= misaligned_next;
    end
  end

endmodule

// File: tb/tb_mask_store.sv
// tb_mask_store
// Directed bench for mask_store. Each applied vector pushes its hand-computed
// result into a queue. A monitor pops one entry after each rising edge and
// compares it with the registered outputs.

module tb_mask_store;

  logic        Clk;
  logic        Reset;
  logic [1:0]  MemAdr;
  logic [31:0] MemData;
  logic [31:0] RegData;
  logic [1:0]  Bytes2Store;
  logic [31:0] out;
  logic [3:0]  ByteEn;
  logic        Misaligned;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [3:0]  en;
    logic        mis;
  } expect_t;

  expect_t scoreboard[$];
  int      checkCount;
  int      failCount;

  mask_store dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .MemAdr      (MemAdr),
    .MemData     (MemData),
    .RegData     (RegData),
    .Bytes2Store (Bytes2Store),
    .out         (out),
    .ByteEn      (ByteEn),
    .Misaligned  (Misaligned)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Drive one vector on the falling edge and record what must appear after
  // the next rising edge.
  task automatic applyStimulus(input string name, input logic rst,
                               input logic [1:0] size, input logic [1:0] adr,
                               input logic [31:0] reg_d, input logic [31:0] mem_d,
                               input logic [31:0] exp_data, input logic [3:0] exp_en,
                               input logic exp_mis);
    expect_t e;
    @(negedge Clk);
    Reset       = rst;
    Bytes2Store = size;
    MemAdr      = adr;
    RegData     = reg_d;
    MemData     = mem_d;
    e.name = name;
    e.data = exp_data;
    e.en   = exp_en;
    e.mis  = exp_mis;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    checkCount++;
    if (out !== e.data) begin
      failCount++;
      $display("[TB] FAIL %s out: got %h expected %h", e.name, out, e.data);
    end
    checkCount++;
    if (ByteEn !== e.en) begin
      failCount++;
      $display("[TB] FAIL %s ByteEn: got %h expected %h", e.name, ByteEn, e.en);
    end
    checkCount++;
    if (Misaligned !== e.mis) begin
      failCount++;
      $display("[TB] FAIL %s Misaligned: got %b expected %b", e.name, Misaligned, e.mis);
    end
  endtask

  // The monitor samples just after each rising edge. Exactly one entry is
  // consumed per edge, which also checks the one-cycle latency with no stalls.
  initial begin
    expect_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput(e);
      end
    end
  end

  localparam logic [31:0] R0 = 32'h0000FFAC;
  localparam logic [31:0] M0 = 32'h0ACFFB19;
  localparam logic [31:0] R1 = 32'hDEADBEEF;
  localparam logic [31:0] M1 = 32'h12345678;

  initial begin
    int waitCycles;
    checkCount  = 0;
    failCount   = 0;
    Reset       = 1'b1;
    MemAdr      = 2'd0;
    MemData     = 32'h0;
    RegData     = 32'h0;
    Bytes2Store = 2'd0;

    // Reset is applied while valid sw inputs are present.
    applyStimulus("reset_sw",  1'b1, 2'd3, 2'd0, R0, M0, 32'h0, 4'h0, 1'b0);
    applyStimulus("reset_sw3", 1'b1, 2'd3, 2'd3, R0, M0, 32'h0, 4'h0, 1'b0);

    // Back-to-back vectors that change size or address every cycle.
    applyStimulus("sw_a0",   1'b0, 2'd3, 2'd0, R0, M0, 32'h0000FFAC, 4'hF, 1'b0);
    applyStimulus("sw_a3",   1'b0, 2'd3, 2'd3, R0, M0, 32'h0000FFAC, 4'hF, 1'b1);
    applyStimulus("sb_a0",   1'b0, 2'd1, 2'd0, R0, M0, 32'h0ACFFBAC, 4'h1, 1'b0);
    applyStimulus("sb_a1",   1'b0, 2'd1, 2'd1, R0, M0, 32'h0ACFAC19, 4'h2, 1'b0);
    applyStimulus("sb_a2",   1'b0, 2'd1, 2'd2, R0, M0, 32'h0AACFB19, 4'h4, 1'b0);
    applyStimulus("sb_a3",   1'b0, 2'd1, 2'd3, R0, M0, 32'hACCFFB19, 4'h8, 1'b0);
    applyStimulus("sh_a0",   1'b0, 2'd2, 2'd0, R0, M0, 32'h0ACFFFAC, 4'h3, 1'b0);
    applyStimulus("sh_a2",   1'b0, 2'd2, 2'd2, R0, M0, 32'hFFACFB19, 4'hC, 1'b0);
    applyStimulus("sh_a3",   1'b0, 2'd2, 2'd3, R0, M0, 32'hFFACFB19, 4'hC, 1'b1);
    applyStimulus("none_a0", 1'b0, 2'd0, 2'd0, R0, M0, 32'h0ACFFB19, 4'h0, 1'b0);

    // Upper RegData bits must not leak into sub-word stores.
    applyStimulus("sb_hi_a2", 1'b0, 2'd1, 2'd2, R1, M1, 32'h12EF5678, 4'h4, 1'b0);
    applyStimulus("sb_hi_a1", 1'b0, 2'd1, 2'd1, R1, M1, 32'h1234EF78, 4'h2, 1'b0);
    applyStimulus("sh_hi_a0", 1'b0, 2'd2, 2'd0, R1, M1, 32'h1234BEEF, 4'h3, 1'b0);
    applyStimulus("sh_hi_a1", 1'b0, 2'd2, 2'd1, R1, M1, 32'h1234BEEF, 4'h3, 1'b1);
    applyStimulus("sh_hi_a2", 1'b0, 2'd2, 2'd2, R1, M1, 32'hBEEF5678, 4'hC, 1'b0);
    applyStimulus("sw_hi_a2", 1'b0, 2'd3, 2'd2, R1, M1, 32'hDEADBEEF, 4'hF, 1'b1);
    applyStimulus("sw_hi_a1", 1'b0, 2'd3, 2'd1, R1, M1, 32'hDEADBEEF, 4'hF, 1'b1);
    applyStimulus("none_a3",  1'b0, 2'd0, 2'd3, R1, M1, 32'h12345678, 4'h0, 1'b0);

    // Reset in the middle of traffic clears the held outputs.
    applyStimulus("reset_mid", 1'b1, 2'd3, 2'd1, R1, M1, 32'h0, 4'h0, 1'b0);
    applyStimulus("sb_after",  1'b0, 2'd1, 2'd3, R1, M1, 32'hEF345678, 4'h8, 1'b0);

    // Let the monitor consume the remaining entries, with a bounded wait.
    waitCycles = 0;
    while (scoreboard.size() > 0 && waitCycles < 20) begin
      @(posedge Clk);
      #2;
      waitCycles++;
    end
    checkCount++;
    if (scoreboard.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", scoreboard.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
